instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the control unit's instruction FIFO.
- Holds the program counter and issues one instruction-memory request at a time using a req/gnt/rvalid handshake.
- Buffers returned instructions in a 2-entry skid buffer and presents them as instr_o/valid_o, honouring the FIFO-full stall.
- Supports PC redirect (branch/flush): discards any in-flight response and restarts fetch at the new PC.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: fetch FSM states and skid-buffer sizing.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } fetch_state_e;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding fetched instructions ahead of the control unit.
// flush_i wins over push_i and pop_i.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = pop_i && (r_count != '0);
    // A full buffer still accepts a push when it is popped in the same cycle.
    assign w_do_push = push_i && ((r_count != CNT_FULL) || w_do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem req/gnt/rvalid, 2-entry skid buffer, redirect.
// Optional performance counters are enabled with `define INSTR_FETCH_PERF_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           PC_STEP    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [WIDTH-1:0]      imem_rdata_i,
    output logic [WIDTH-1:0]      instr_o,
    output logic                  valid_o,
    input  logic                  stall_i,
`ifdef INSTR_FETCH_PERF_EN
    output logic [31:0]           perf_fetched_o,
    output logic [31:0]           perf_stall_o,
`endif
    output logic [ADDR_WIDTH-1:0] pc_o
);

    localparam logic [ADDR_WIDTH-1:0] PC_INC  = ADDR_WIDTH'(PC_STEP);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  r_req;
    logic                  w_req_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [WIDTH-1:0] w_head;

    // A redirect cancels both the buffered data and any pop in the same cycle.
    assign w_pop  = !w_empty && !stall_i && !redirect_valid_i;
    assign w_push = (r_state == WAIT) && imem_rvalid_i && !redirect_valid_i;

    fetch_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_valid_i),
        .push_i  (w_push),
        .data_i  (imem_rdata_i),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_req   <= w_req_next;
            r_addr  <= w_addr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_req_next   = r_req;
        w_addr_next  = r_addr;

        unique case (r_state)
            IDLE: begin
                if (!redirect_valid_i && enable_i && (w_count <= CNT_ONE)) begin
                    w_state_next = REQ;
                    w_req_next   = 1'b1;
                    w_addr_next  = r_pc;
                end
            end
            REQ: begin
                if (imem_gnt_i) begin
                    w_req_next   = 1'b0;
                    w_pc_next    = r_pc + PC_INC;
                    w_state_next = redirect_valid_i ? DRAIN : WAIT;
                end else if (redirect_valid_i) begin
                    w_req_next   = 1'b0;
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                if (redirect_valid_i) begin
                    w_state_next = imem_rvalid_i ? IDLE : DRAIN;
                end else if (imem_rvalid_i) begin
                    // Back-to-back issue only if the buffer keeps a free slot after this push.
                    if (enable_i && ((w_count == '0) || w_pop)) begin
                        w_state_next = REQ;
                        w_req_next   = 1'b1;
                        w_addr_next  = r_pc;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (imem_rvalid_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (redirect_valid_i) begin
            w_pc_next = redirect_pc_i;
        end
    end

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_addr;
    assign instr_o     = w_head;
    assign valid_o     = !w_empty;
    assign pc_o        = r_pc;

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!w_empty && stall_i) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_stall_o   = r_perf_stall;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model answers requests, a monitor checks
// granted addresses and delivered instructions against queues filled by the directed scenarios.
module tb_instr_fetch_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 32;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             enable_i;
    logic             redirect_valid_i;
    logic [AW-1:0]    redirect_pc_i;
    logic             imem_req_o;
    logic [AW-1:0]    imem_addr_o;
    logic             imem_gnt_i;
    logic             imem_rvalid_i;
    logic [WIDTH-1:0] imem_rdata_i;
    logic [WIDTH-1:0] instr_o;
    logic             valid_o;
    logic             stall_i;
    logic [AW-1:0]    pc_o;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0]      perf_fetched_o;
    logic [31:0]      perf_stall_o;
`endif

    always #5 clk_i = ~clk_i;

    instr_fetch_unit #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (AW),
        .RESET_PC   (32'h0000_0100),
        .PC_STEP    (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .enable_i         (enable_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_gnt_i       (imem_gnt_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .instr_o          (instr_o),
        .valid_o          (valid_o),
        .stall_i          (stall_i),
`ifdef INSTR_FETCH_PERF_EN
        .perf_fetched_o   (perf_fetched_o),
        .perf_stall_o     (perf_stall_o),
`endif
        .pc_o             (pc_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Memory model knobs, written only by the stimulus process.
    int allowed   = 0;
    int gnt_delay = 0;
    int rsp_delay = 1;

    int gnt_seen = 0;
    logic [AW-1:0]    exp_addr_q[$];
    logic [WIDTH-1:0] exp_instr_q[$];
    int gnt_cyc[$];
    int pop_cyc[$];

    function automatic logic [WIDTH-1:0] mem_word(input logic [AW-1:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_gnt(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && gnt_seen < target; i++) begin
            @(negedge clk_i);
            #1;
        end
        chk("grant_wait", 32'(gnt_seen >= target), 32'd1);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && (exp_addr_q.size() + exp_instr_q.size()) != 0; i++) begin
            @(negedge clk_i);
            #1;
        end
        chk(name, 32'(exp_addr_q.size() + exp_instr_q.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    // Instruction memory: grants after gnt_delay waiting cycles, answers rsp_delay cycles later.
    initial begin
        int granted;
        int wait_cnt;
        int rsp_wait;
        logic [AW-1:0] rsp_addr;
        granted       = 0;
        wait_cnt      = 0;
        rsp_wait      = 0;
        rsp_addr      = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(posedge clk_i);
            #2;
            imem_gnt_i    = 1'b0;
            imem_rvalid_i = 1'b0;
            if (rsp_wait > 0) begin
                rsp_wait--;
                if (rsp_wait == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(rsp_addr);
                end
            end
            if (imem_req_o && granted < allowed) begin
                if (wait_cnt >= gnt_delay) begin
                    imem_gnt_i = 1'b1;
                    granted++;
                    wait_cnt = 0;
                    rsp_addr = imem_addr_o;
                    rsp_wait = rsp_delay;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: compares every grant and every accepted instruction with the scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (imem_req_o && imem_gnt_i) begin
                    gnt_seen++;
                    gnt_cyc.push_back(cyc);
                    if (exp_addr_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL grant_addr: unexpected grant of %h", imem_addr_o);
                    end else begin
                        chk("grant_addr", imem_addr_o, exp_addr_q.pop_front());
                    end
                end
                if (valid_o && !stall_i && !redirect_valid_i) begin
                    pop_cyc.push_back(cyc);
                    if (exp_instr_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL instr_out: unexpected instruction %h", instr_o);
                    end else begin
                        chk("instr_out", instr_o, exp_instr_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni           = 1'b0;
        enable_i         = 1'b1;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = '0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0000_0100);

        // Streaming fetch: 1 instruction per 2 cycles
        allowed += 3;
        exp_addr_q  = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        exp_instr_q = '{32'hA500_0100, 32'hA500_0104, 32'hA500_0108};
        tick();
        rst_ni = 1'b1;
        wait_drain("stream_drain", 40);
        if (gnt_cyc.size() >= 3 && pop_cyc.size() >= 3) begin
            chk("stream_latency", 32'(pop_cyc[0] - gnt_cyc[0]), 32'd2);
            chk("stream_gap01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
            chk("stream_gap12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
        end else begin
            chk("stream_count", 32'(pop_cyc.size()), 32'd3);
        end

        // Stall: buffer fills to 2, no further requests, output held
        tick();
        stall_i = 1'b1;
        allowed += 3;
        exp_addr_q  = '{32'h0000_010C, 32'h0000_0110, 32'h0000_0114};
        exp_instr_q = '{32'hA500_010C, 32'hA500_0110, 32'hA500_0114};
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 6) begin
                @(negedge clk_i);
                chk("stall_valid", 32'(valid_o), 32'd1);
                chk("stall_instr", instr_o, 32'hA500_010C);
                chk("stall_no_req", 32'(imem_req_o), 32'd0);
            end
        end
        tick();
        stall_i = 1'b0;
        wait_drain("stall_drain", 40);

        // Redirect while in WAIT with a buffered instruction
        tick();
        stall_i   = 1'b1;
        rsp_delay = 3;
        allowed += 2;
        exp_addr_q = '{32'h0000_0118, 32'h0000_011C};
        wait_gnt(gnt_seen + 2, 40);
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0200;
        @(negedge clk_i);
        chk("wait_pre_valid", 32'(valid_o), 32'd1);
        chk("wait_pre_instr", instr_o, 32'hA500_0118);
        tick();
        redirect_valid_i = 1'b0;
        @(negedge clk_i);
        chk("wait_redir_valid", 32'(valid_o), 32'd0);
        chk("wait_redir_pc", pc_o, 32'h0000_0200);
        chk("wait_redir_req", 32'(imem_req_o), 32'd0);
        tick();
        stall_i   = 1'b0;
        rsp_delay = 1;
        allowed += 1;
        exp_addr_q.push_back(32'h0000_0200);
        exp_instr_q.push_back(32'hA500_0200);
        wait_drain("wait_redir_drain", 40);

        // Redirect in the same cycle as rvalid: no DRAIN
        tick();
        allowed += 1;
        exp_addr_q.push_back(32'h0000_0204);
        wait_gnt(gnt_seen + 1, 20);
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0200;
        tick();
        redirect_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rv_redir_valid", 32'(valid_o), 32'd0);
        chk("rv_redir_pc", pc_o, 32'h0000_0200);
        chk("rv_redir_req", 32'(imem_req_o), 32'd0);
        allowed += 1;
        exp_addr_q.push_back(32'h0000_0200);
        exp_instr_q.push_back(32'hA500_0200);
        tick();
        @(negedge clk_i);
        chk("rv_next_req", 32'(imem_req_o), 32'd1);
        chk("rv_next_addr", imem_addr_o, 32'h0000_0200);
        wait_drain("rv_drain", 40);

        // Grant delayed by 5 cycles: request held stable
        tick();
        gnt_delay = 5;
        allowed += 1;
        exp_addr_q.push_back(32'h0000_0204);
        exp_instr_q.push_back(32'hA500_0204);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("gdly_req", 32'(imem_req_o), 32'd1);
            chk("gdly_addr", imem_addr_o, 32'h0000_0204);
            chk("gdly_gnt", 32'(imem_gnt_i), 32'd0);
            tick();
        end
        wait_drain("gdly_drain", 40);

        // Redirect while waiting for a grant drops the request
        tick();
        allowed += 1;
        exp_addr_q.push_back(32'h0000_0300);
        exp_instr_q.push_back(32'hA500_0300);
        tick();
        tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0300;
        @(negedge clk_i);
        chk("req_redir_held", imem_addr_o, 32'h0000_0208);
        tick();
        redirect_valid_i = 1'b0;
        @(negedge clk_i);
        chk("req_redir_drop", 32'(imem_req_o), 32'd0);
        chk("req_redir_pc", pc_o, 32'h0000_0300);
        wait_drain("req_redir_drain", 60);

        // PC wrap at the top of the address space
        tick();
        gnt_delay        = 0;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'hFFFF_FFFC;
        tick();
        redirect_valid_i = 1'b0;
        allowed += 2;
        exp_addr_q  = '{32'hFFFF_FFFC, 32'h0000_0000};
        exp_instr_q = '{32'hA5FF_FFFC, 32'hA500_0000};
        wait_drain("wrap_drain", 40);
        tick();
        @(negedge clk_i);
        chk("wrap_pc", pc_o, 32'h0000_0004);
        chk("wrap_next_addr", imem_addr_o, 32'h0000_0004);
        chk("wrap_next_req", 32'(imem_req_o), 32'd1);

        repeat (4) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
